// File: rtl/bsg_manycore_pkt_decode_endpoint_pkg.sv
// Shared manycore definitions: packet layout macros, op encodings, lock count
// and the decode FSM states used by the receive-side packet endpoint.

`ifndef BSG_MANYCORE_PACKET_MACROS
`define BSG_MANYCORE_PACKET_MACROS

`define BSG_MANYCORE_PACKET_WIDTH(addr_width_mp, data_width_mp, x_cord_width_mp, y_cord_width_mp) \
  (2 + ((data_width_mp) >> 3) + (addr_width_mp) + (data_width_mp) + 2 * ((x_cord_width_mp) + (y_cord_width_mp)))

`define DECLARE_BSG_MANYCORE_PACKET_S(addr_width_mp, data_width_mp, x_cord_width_mp, y_cord_width_mp) \
  typedef struct packed { \
    logic [1:0]                      op; \
    logic [((data_width_mp)>>3)-1:0] op_ex; \
    logic [(addr_width_mp)-1:0]      addr; \
    logic [(data_width_mp)-1:0]      data; \
    logic [(y_cord_width_mp)-1:0]    from_y_cord; \
    logic [(x_cord_width_mp)-1:0]    from_x_cord; \
    logic [(y_cord_width_mp)-1:0]    y_cord; \
    logic [(x_cord_width_mp)-1:0]    x_cord; \
  } bsg_manycore_packet_s

`endif

package bsg_manycore_pkt_decode_endpoint_pkg;

  typedef enum logic [1:0] {
    e_op_illegal    = 2'b00,
    e_op_store      = 2'b01,
    e_op_store_high = 2'b10,
    e_op_lock_req   = 2'b11
  } bsg_manycore_op_e;

  localparam int bsg_manycore_lock_num_gp = 4;

  typedef enum logic [1:0] {
    e_decode_idle      = 2'b00,
    e_decode_wait_lock = 2'b01,
    e_decode_grant     = 2'b10
  } bsg_manycore_decode_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO. Accepts a word whenever it is not full and
// presents its oldest word on data_o until the consumer takes it with yumi_i.

module bsg_two_fifo
  #(parameter int width_p = 8)
  (input  logic               clk_i
   , input  logic               reset_i
   , output logic               ready_o
   , input  logic [width_p-1:0] data_i
   , input  logic               v_i
   , output logic               v_o
   , output logic [width_p-1:0] data_o
   , input  logic               yumi_i
  );

  logic [width_p-1:0] mem_r [2];
  logic               head_r;
  logic               tail_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[head_r];

  // Storage needs no reset: occupancy alone decides whether data_o is meaningful.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[tail_r] <= data_i;
  end

  // Pointers and occupancy move independently so enqueue and dequeue can share a cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

endmodule

// File: rtl/bsg_manycore_pkt_decode_endpoint.sv
// Receive endpoint for manycore packets. Buffers incoming packets, turns store
// ops into masked local memory writes and arbitrates a 4-entry local lock
// table, returning grants to the requesting tile's coordinates.

module bsg_manycore_pkt_decode_endpoint
  import bsg_manycore_pkt_decode_endpoint_pkg::*;
  #(parameter int x_cord_width_p    = 4
    , parameter int y_cord_width_p    = 4
    , parameter int data_width_p      = 32
    , parameter int addr_width_p      = 12
    , parameter int packet_width_lp   = `BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
    , parameter int store_cnt_width_p = 16
  )
  (input  logic                           clk_i
   , input  logic                           reset_i
   , input  logic                           v_i
   , input  logic [packet_width_lp-1:0]     data_i
   , output logic                           ready_o
   , output logic                           mem_v_o
   , output logic [addr_width_p:0]          mem_addr_o
   , output logic [data_width_p-1:0]        mem_data_o
   , output logic [(data_width_p>>3)-1:0]   mem_mask_o
   , input  logic                           mem_yumi_i
   , output logic                           grant_v_o
   , output logic [1:0]                     grant_lock_num_o
   , output logic [x_cord_width_p-1:0]      grant_x_cord_o
   , output logic [y_cord_width_p-1:0]      grant_y_cord_o
   , input  logic                           grant_ready_i
   , input  logic                           rel_lock_v_i
   , input  logic [1:0]                     rel_lock_num_i
   , output logic [bsg_manycore_lock_num_gp-1:0] lock_held_o
   , output logic [store_cnt_width_p-1:0]   store_cnt_o
   , output logic                           err_o
  );

  `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam logic [store_cnt_width_p-1:0] cnt_one_lp = {{(store_cnt_width_p-1){1'b0}}, 1'b1};

  bsg_manycore_packet_s                  head;
  logic [packet_width_lp-1:0]            fifo_data;
  logic                                  fifo_ready;
  logic                                  fifo_v;
  logic                                  fifo_yumi;
  bsg_manycore_op_e                      head_op;
  logic [1:0]                            req_lock;
  logic                                  lock_free;

  bsg_manycore_decode_state_e            state_r, state_n;
  logic [bsg_manycore_lock_num_gp-1:0]   held_r, held_n;
  logic [1:0]                            grant_num_r, grant_num_n;
  logic [x_cord_width_p-1:0]             grant_x_r, grant_x_n;
  logic [y_cord_width_p-1:0]             grant_y_r, grant_y_n;
  logic [store_cnt_width_p-1:0]          store_cnt_r;
  logic                                  store_done;
  logic                                  acquire;
  logic                                  mem_v;
  logic                                  op_err;
  logic                                  rel_err;
  logic                                  yumi_err;
  logic                                  unused_dest_cord;

  bsg_two_fifo #(.width_p(packet_width_lp)) input_fifo
    (.clk_i   (clk_i)
     , .reset_i (reset_i)
     , .ready_o (fifo_ready)
     , .data_i  (data_i)
     , .v_i     (v_i)
     , .v_o     (fifo_v)
     , .data_o  (fifo_data)
     , .yumi_i  (fifo_yumi)
    );

  assign head      = fifo_data;
  assign head_op   = bsg_manycore_op_e'(head.op);
  assign req_lock  = head.addr[5:4];
  // A lock released this very cycle counts as free so the waiting requester wins it.
  assign lock_free = ~held_r[req_lock] | (rel_lock_v_i & (rel_lock_num_i == req_lock));

  // The destination coordinates already steered the packet here and carry no further meaning.
  assign unused_dest_cord = ^{head.x_cord, head.y_cord};

  // Decode the fifo head, sequence lock grants and fold the release into the lock table.
  always_comb begin
    state_n    = state_r;
    held_n     = held_r;
    grant_num_n = grant_num_r;
    grant_x_n  = grant_x_r;
    grant_y_n  = grant_y_r;
    fifo_yumi  = 1'b0;
    store_done = 1'b0;
    acquire    = 1'b0;
    mem_v      = 1'b0;
    op_err     = 1'b0;

    if (rel_lock_v_i) held_n[rel_lock_num_i] = 1'b0;

    case (state_r)
      e_decode_idle: begin
        if (fifo_v) begin
          case (head_op)
            e_op_store, e_op_store_high: begin
              mem_v = 1'b1;
              if (mem_yumi_i) begin
                fifo_yumi  = 1'b1;
                store_done = 1'b1;
              end
            end
            e_op_lock_req: begin
              if (lock_free) acquire = 1'b1;
              else state_n = e_decode_wait_lock;
            end
            default: begin
              fifo_yumi = 1'b1;
              op_err    = 1'b1;
            end
          endcase
        end
      end
      e_decode_wait_lock: begin
        if (fifo_v && lock_free) acquire = 1'b1;
      end
      e_decode_grant: begin
        if (grant_ready_i) state_n = e_decode_idle;
      end
      default: state_n = e_decode_idle;
    endcase

    if (acquire) begin
      held_n[req_lock] = 1'b1;
      grant_num_n      = req_lock;
      grant_x_n        = head.from_x_cord;
      grant_y_n        = head.from_y_cord;
      fifo_yumi        = 1'b1;
      state_n          = e_decode_grant;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_decode_idle;
    else         state_r <= state_n;
  end

  // Lock table, latched grant fields and the completed-store counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      held_r      <= '0;
      grant_num_r <= '0;
      grant_x_r   <= '0;
      grant_y_r   <= '0;
      store_cnt_r <= '0;
    end else begin
      held_r      <= held_n;
      grant_num_r <= grant_num_n;
      grant_x_r   <= grant_x_n;
      grant_y_r   <= grant_y_n;
      if (store_done) store_cnt_r <= store_cnt_r + cnt_one_lp;
    end
  end

  assign rel_err  = rel_lock_v_i & ~held_r[rel_lock_num_i];
  assign yumi_err = mem_yumi_i & ~mem_v;

  assign ready_o          = fifo_ready & ~reset_i;
  assign mem_v_o          = mem_v;
  assign mem_addr_o       = mem_v ? {(head_op == e_op_store_high), head.addr} : '0;
  assign mem_data_o       = mem_v ? head.data : '0;
  assign mem_mask_o       = mem_v ? head.op_ex : '0;
  assign grant_v_o        = (state_r == e_decode_grant);
  assign grant_lock_num_o = grant_v_o ? grant_num_r : '0;
  assign grant_x_cord_o   = grant_v_o ? grant_x_r : '0;
  assign grant_y_cord_o   = grant_v_o ? grant_y_r : '0;
  assign lock_held_o      = held_r;
  assign store_cnt_o      = store_cnt_r;
  assign err_o            = ~reset_i & (op_err | rel_err | yumi_err);

endmodule

// File: tb/tb_bsg_manycore_pkt_decode_endpoint.sv
// Self-checking bench for the manycore packet decode endpoint: directed
// scenarios followed by randomized traffic, all compared every cycle against a
// transaction-level model (packet queue, lock bitmap, pending grant, counter).

module tb_bsg_manycore_pkt_decode_endpoint;

  localparam int x_w    = 4;
  localparam int y_w    = 4;
  localparam int data_w = 32;
  localparam int addr_w = 12;
  localparam int mask_w = data_w >> 3;
  localparam int pkt_w  = `BSG_MANYCORE_PACKET_WIDTH(addr_w, data_w, x_w, y_w);

  `DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w);

  logic              clk_i;
  logic              reset_i;
  logic              v_i;
  logic [pkt_w-1:0]  data_i;
  logic              ready_o;
  logic              mem_v_o;
  logic [addr_w:0]   mem_addr_o;
  logic [data_w-1:0] mem_data_o;
  logic [mask_w-1:0] mem_mask_o;
  logic              mem_yumi_i;
  logic              grant_v_o;
  logic [1:0]        grant_lock_num_o;
  logic [x_w-1:0]    grant_x_cord_o;
  logic [y_w-1:0]    grant_y_cord_o;
  logic              grant_ready_i;
  logic              rel_lock_v_i;
  logic [1:0]        rel_lock_num_i;
  logic [3:0]        lock_held_o;
  logic [15:0]       store_cnt_o;
  logic              err_o;

  int num_vectors     = 0;
  int num_miscompares = 0;

  bsg_manycore_packet_s model_q[$];
  logic [3:0]           model_held;
  bit                   model_grant_pend;
  logic [1:0]           model_grant_num;
  logic [x_w-1:0]       model_grant_x;
  logic [y_w-1:0]       model_grant_y;
  logic [15:0]          model_cnt;

  logic                 obs_ready;
  logic                 obs_err;
  logic                 obs_grant_v;
  logic [1:0]           obs_grant_num;
  logic [x_w-1:0]       obs_grant_x;
  logic [y_w-1:0]       obs_grant_y;
  logic [addr_w:0]      obs_mem_addr;

  bsg_manycore_pkt_decode_endpoint #(
    .x_cord_width_p(x_w), .y_cord_width_p(y_w), .data_width_p(data_w),
    .addr_width_p(addr_w), .store_cnt_width_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i), .grant_v_o(grant_v_o),
    .grant_lock_num_o(grant_lock_num_o), .grant_x_cord_o(grant_x_cord_o),
    .grant_y_cord_o(grant_y_cord_o), .grant_ready_i(grant_ready_i),
    .rel_lock_v_i(rel_lock_v_i), .rel_lock_num_i(rel_lock_num_i),
    .lock_held_o(lock_held_o), .store_cnt_o(store_cnt_o), .err_o(err_o)
  );

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bsg_manycore_packet_s make_pkt(input logic [1:0] op, input logic [mask_w-1:0] op_ex,
                                                    input logic [addr_w-1:0] addr, input logic [data_w-1:0] data,
                                                    input logic [x_w-1:0] fx, input logic [y_w-1:0] fy);
    bsg_manycore_packet_s p;
    p = '0;
    p.op          = op;
    p.op_ex       = op_ex;
    p.addr        = addr;
    p.data        = data;
    p.from_x_cord = fx;
    p.from_y_cord = fy;
    return p;
  endfunction

  function automatic bsg_manycore_packet_s rand_pkt();
    logic [31:0] r;
    logic [31:0] d;
    logic [1:0]  op;
    int          sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)     op = 2'b00;
    else if (sel < 4) op = 2'b01;
    else if (sel < 6) op = 2'b10;
    else              op = 2'b11;
    r = $urandom;
    d = $urandom;
    return make_pkt(op, r[3:0], r[15:4], d, r[19:16], r[23:20]);
  endfunction

  function automatic bit model_store_at_head();
    if (model_q.size() == 0 || model_grant_pend) return 1'b0;
    return (model_q[0].op == 2'b01) || (model_q[0].op == 2'b10);
  endfunction

  task automatic clear_model();
    model_q.delete();
    model_held       = 4'b0000;
    model_grant_pend = 1'b0;
    model_grant_num  = 2'd0;
    model_grant_x    = '0;
    model_grant_y    = '0;
    model_cnt        = 16'd0;
  endtask

  // One clock of traffic: drive inputs, predict and compare every output, advance the model.
  task automatic applyStimulus(input bit v, input bsg_manycore_packet_s pkt, input bit yumi,
                               input bit gr, input bit rel_v, input logic [1:0] rel_num);
    bit                   head_v, is_store, is_lock, is_illegal, lock_free, acquire, exp_err, exp_ready;
    bsg_manycore_packet_s head;
    logic [1:0]           lock_idx;
    logic [addr_w:0]      exp_addr;
    logic [3:0]           next_held;

    v_i = v; data_i = pkt; mem_yumi_i = yumi; grant_ready_i = gr;
    rel_lock_v_i = rel_v; rel_lock_num_i = rel_num;

    head_v     = model_q.size() > 0;
    head       = head_v ? model_q[0] : '0;
    lock_idx   = head.addr[5:4];
    is_store   = head_v && !model_grant_pend && (head.op == 2'b01 || head.op == 2'b10);
    is_lock    = head_v && !model_grant_pend && (head.op == 2'b11);
    is_illegal = head_v && !model_grant_pend && (head.op == 2'b00);
    lock_free  = !model_held[lock_idx] || (rel_v && rel_num == lock_idx);
    acquire    = is_lock && lock_free;
    exp_err    = is_illegal || (rel_v && !model_held[rel_num]) || (yumi && !is_store);
    exp_ready  = model_q.size() < 2;
    exp_addr   = is_store ? {(head.op == 2'b10), head.addr} : '0;

    @(negedge clk_i);
    obs_ready = ready_o; obs_err = err_o; obs_grant_v = grant_v_o; obs_grant_num = grant_lock_num_o;
    obs_grant_x = grant_x_cord_o; obs_grant_y = grant_y_cord_o; obs_mem_addr = mem_addr_o;
    checkOutput("ready",     64'(ready_o),          64'(exp_ready));
    checkOutput("mem_v",     64'(mem_v_o),          64'(is_store));
    checkOutput("mem_addr",  64'(mem_addr_o),       64'(exp_addr));
    checkOutput("mem_data",  64'(mem_data_o),       is_store ? 64'(head.data) : 64'd0);
    checkOutput("mem_mask",  64'(mem_mask_o),       is_store ? 64'(head.op_ex) : 64'd0);
    checkOutput("grant_v",   64'(grant_v_o),        64'(model_grant_pend));
    checkOutput("grant_num", 64'(grant_lock_num_o), model_grant_pend ? 64'(model_grant_num) : 64'd0);
    checkOutput("grant_x",   64'(grant_x_cord_o),   model_grant_pend ? 64'(model_grant_x) : 64'd0);
    checkOutput("grant_y",   64'(grant_y_cord_o),   model_grant_pend ? 64'(model_grant_y) : 64'd0);
    checkOutput("lock_held", 64'(lock_held_o),      64'(model_held));
    checkOutput("store_cnt", 64'(store_cnt_o),      64'(model_cnt));
    checkOutput("err",       64'(err_o),            64'(exp_err));

    next_held = model_held;
    if (rel_v)   next_held[rel_num]  = 1'b0;
    if (acquire) next_held[lock_idx] = 1'b1;
    model_held = next_held;
    if (model_grant_pend && gr) model_grant_pend = 1'b0;
    if (acquire) begin
      model_grant_pend = 1'b1;
      model_grant_num  = lock_idx;
      model_grant_x    = head.from_x_cord;
      model_grant_y    = head.from_y_cord;
    end
    if (is_store && yumi) model_cnt = model_cnt + 16'd1;
    if ((is_store && yumi) || is_illegal || acquire) void'(model_q.pop_front());
    if (v && exp_ready) model_q.push_back(pkt);

    @(posedge clk_i);
    #1;
  endtask

  // Two reset cycles: ready/err must be low throughout, everything else clear after the first edge.
  task automatic applyReset();
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; mem_yumi_i = 1'b0;
    grant_ready_i = 1'b0; rel_lock_v_i = 1'b0; rel_lock_num_i = 2'd0;
    @(negedge clk_i);
    checkOutput("rst_ready_pre", 64'(ready_o), 64'd0);
    checkOutput("rst_err_pre",   64'(err_o),   64'd0);
    @(posedge clk_i);
    #1;
    clear_model();
    @(negedge clk_i);
    checkOutput("rst_ready",     64'(ready_o),     64'd0);
    checkOutput("rst_mem_v",     64'(mem_v_o),     64'd0);
    checkOutput("rst_mem_addr",  64'(mem_addr_o),  64'd0);
    checkOutput("rst_grant_v",   64'(grant_v_o),   64'd0);
    checkOutput("rst_lock_held", 64'(lock_held_o), 64'd0);
    checkOutput("rst_store_cnt", 64'(store_cnt_o), 64'd0);
    checkOutput("rst_err",       64'(err_o),       64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic runRandom(input int cycles);
    bit         rv, ry, rg, rr;
    logic [1:0] rn;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      rv = ($urandom_range(0, 2) != 0);
      ry = model_store_at_head() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      rg = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 5) == 0);
      rn = 2'($urandom_range(0, 3));
      applyStimulus(rv, rand_pkt(), ry, rg, rr, rn);
    end
  endtask

  // Directed scenarios, then randomized traffic with a reset in the middle.
  initial begin
    bsg_manycore_packet_s idle_pkt;
    bsg_manycore_packet_s st_a, st_b, st_c;
    idle_pkt = '0;
    clear_model();
    applyReset();

    // Plain store into the low region.
    applyStimulus(1, make_pkt(2'b01, 4'b0011, 12'h010, 32'hDEADBEEF, 0, 0), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 1, 0, 0, 0);
    checkOutput("store_addr_low", 64'(obs_mem_addr), 64'h010);
    checkOutput("store_cnt_one",  64'(store_cnt_o),  64'd1);

    // Store into the high region sets the top address bit.
    applyStimulus(1, make_pkt(2'b10, 4'b1111, 12'h004, 32'h12345678, 0, 0), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 1, 0, 0, 0);
    checkOutput("store_addr_high", 64'(obs_mem_addr), 64'h1004);

    // Back-to-back stores against a stalled memory port.
    st_a = make_pkt(2'b01, 4'b0001, 12'h100, 32'hA0A0A0A0, 0, 0);
    st_b = make_pkt(2'b01, 4'b0010, 12'h101, 32'hB1B1B1B1, 0, 0);
    st_c = make_pkt(2'b10, 4'b0100, 12'h102, 32'hC2C2C2C2, 0, 0);
    applyStimulus(1, st_a, 0, 0, 0, 0);
    applyStimulus(1, st_b, 0, 0, 0, 0);
    applyStimulus(1, st_c, 0, 0, 0, 0);
    checkOutput("fifo_full_ready", 64'(obs_ready), 64'd0);
    applyStimulus(1, st_c, 0, 0, 0, 0);
    applyStimulus(1, st_c, 1, 0, 0, 0);
    applyStimulus(1, st_c, 1, 0, 0, 0);
    applyStimulus(0, idle_pkt, 1, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    checkOutput("store_cnt_five", 64'(store_cnt_o), 64'd5);

    // Free lock 2 granted to (3,1), then a second request stalls until release.
    applyStimulus(1, make_pkt(2'b11, 4'b0000, 12'h020, 32'h0, 3, 1), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 1, 0, 0);
    checkOutput("grant_lock2_v",   64'(obs_grant_v),   64'd1);
    checkOutput("grant_lock2_num", 64'(obs_grant_num), 64'd2);
    checkOutput("grant_lock2_x",   64'(obs_grant_x),   64'd3);
    checkOutput("grant_lock2_y",   64'(obs_grant_y),   64'd1);
    checkOutput("held_lock2",      64'(lock_held_o),   64'b0100);
    applyStimulus(1, make_pkt(2'b11, 4'b0000, 12'h0A0, 32'h0, 5, 6), 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, idle_pkt, 0, 1, 0, 0);
    checkOutput("stall_no_grant", 64'(obs_grant_v), 64'd0);
    applyStimulus(0, idle_pkt, 0, 0, 1, 2'd2);
    applyStimulus(0, idle_pkt, 0, 1, 0, 0);
    checkOutput("regrant_v", 64'(obs_grant_v), 64'd1);
    checkOutput("regrant_x", 64'(obs_grant_x), 64'd5);
    applyStimulus(0, idle_pkt, 0, 0, 1, 2'd2);
    checkOutput("held_after_rel", 64'(lock_held_o), 64'b0000);

    // Same-cycle release and re-request of lock 1.
    applyStimulus(1, make_pkt(2'b11, 4'b0000, 12'h010, 32'h0, 1, 2), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    applyStimulus(1, make_pkt(2'b11, 4'b0000, 12'h310, 32'h0, 7, 4), 0, 1, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 1, 2'd1);
    checkOutput("same_cycle_err", 64'(obs_err), 64'd0);
    applyStimulus(0, idle_pkt, 0, 1, 0, 0);
    checkOutput("same_cycle_grant", 64'(obs_grant_v), 64'd1);
    checkOutput("same_cycle_held",  64'(lock_held_o), 64'b0010);

    // Illegal op and release of a free lock each pulse err_o.
    applyStimulus(1, make_pkt(2'b00, 4'b1010, 12'h055, 32'h55555555, 0, 0), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    checkOutput("illegal_err", 64'(obs_err), 64'd1);
    applyStimulus(0, idle_pkt, 0, 0, 1, 2'd3);
    checkOutput("free_rel_err",  64'(obs_err),     64'd1);
    checkOutput("free_rel_held", 64'(lock_held_o), 64'b0010);

    // Reset while a request waits on held lock 1.
    applyStimulus(1, make_pkt(2'b11, 4'b0000, 12'h010, 32'h0, 2, 2), 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    applyStimulus(0, idle_pkt, 0, 0, 0, 0);
    applyReset();
    checkOutput("wait_reset_held", 64'(lock_held_o), 64'd0);

    runRandom(250);
    applyReset();
    runRandom(250);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
